// File: rtl/noise_envelope.sv
// Amplitude envelope for the noise voice: an ADSR level generator driven by an
// envelope-tick prescaler, multiplied into the 6-bit noise sample stream.
module noise_envelope #(
  parameter int unsigned PRESCALE = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Sample,
  input  logic       KeyOn,
  input  logic       KeyOff,
  input  logic [3:0] AttackRate,
  input  logic [3:0] DecayRate,
  input  logic [3:0] SustainLvl,
  input  logic [3:0] ReleaseRate,
  output logic [5:0] Output,
  output logic [5:0] Level,
  output logic [2:0] Phase,
  output logic       Busy
);

  localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [5:0]  LVL_MAX  = 6'd63;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } phase_t;

  logic [PW-1:0] presc;
  logic          tick_c;
  phase_t        phase_q, phase_n;
  logic [5:0]    level_n;
  logic [3:0]    cnt_q, cnt_n;
  logic [3:0]    rate_c;
  logic          step_c;
  logic [5:0]    target_c;
  logic [5:0]    scaled_c;

  assign tick_c   = (presc == PW'(PRESCALE - 1));
  assign target_c = {SustainLvl, 2'b00};
  assign scaled_c = 6'((12'(Sample) * 12'(Level)) >> 6);
  assign Phase    = phase_q;

  // Free-running envelope-tick prescaler; the tick fires on the edge it wraps to 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
    end else if (tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Next-state, level and step-counter logic for the ADSR sequencer.
  always_comb begin
    phase_n = phase_q;
    level_n = Level;
    cnt_n   = cnt_q;
    rate_c  = ReleaseRate;
    step_c  = 1'b0;

    case (phase_q)
      ATTACK:  rate_c = AttackRate;
      DECAY:   rate_c = DecayRate;
      default: rate_c = ReleaseRate;
    endcase
    step_c = tick_c && (cnt_q == rate_c);

    if (KeyOn) begin
      phase_n = ATTACK;
      cnt_n   = '0;
    end else if (KeyOff && (phase_q == ATTACK || phase_q == DECAY || phase_q == SUSTAIN)) begin
      phase_n = RELEASE;
      cnt_n   = '0;
    end else begin
      case (phase_q)
        ATTACK: begin
          if (Level == LVL_MAX) begin
            phase_n = DECAY;
            cnt_n   = '0;
          end else if (tick_c) begin
            if (step_c) begin
              level_n = Level + 6'd1;
              cnt_n   = '0;
              if (Level == LVL_MAX - 6'd1) begin
                phase_n = DECAY;
              end
            end else begin
              cnt_n = cnt_q + 4'd1;
            end
          end
        end
        DECAY: begin
          if (Level <= target_c) begin
            phase_n = SUSTAIN;
            cnt_n   = '0;
          end else if (tick_c) begin
            if (step_c) begin
              level_n = Level - 6'd1;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_q + 4'd1;
            end
          end
        end
        SUSTAIN: begin
          cnt_n = '0;
        end
        RELEASE: begin
          if (Level == 6'd0) begin
            phase_n = IDLE;
            cnt_n   = '0;
          end else if (tick_c) begin
            if (step_c) begin
              level_n = Level - 6'd1;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_q + 4'd1;
            end
          end
        end
        IDLE: begin
          cnt_n = '0;
        end
        default: begin
          phase_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // State, level, busy and shaped-output registers; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q <= IDLE;
      Level   <= '0;
      cnt_q   <= '0;
      Busy    <= 1'b0;
      Output  <= '0;
    end else begin
      phase_q <= phase_n;
      Level   <= level_n;
      cnt_q   <= cnt_n;
      Busy    <= (phase_n != IDLE);
      Output  <= (Level == LVL_MAX) ? Sample : scaled_c;
    end
  end

endmodule

// File: tb/tb_noise_envelope.sv
// Scoreboard bench for noise_envelope: stimulus queues cycle-stamped
// expectations, a monitor on the falling edge pops and compares them.
module tb_noise_envelope;

  localparam int unsigned PRESCALE = 4;
  localparam int M_OUT = 1;
  localparam int M_ST  = 14;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Sample = 6'd63;
  logic       KeyOn = 1'b1;
  logic       KeyOff = 1'b0;
  logic [3:0] AttackRate = 4'd0;
  logic [3:0] DecayRate = 4'd0;
  logic [3:0] SustainLvl = 4'd8;
  logic [3:0] ReleaseRate = 4'd0;
  logic [5:0] Output;
  logic [5:0] Level;
  logic [2:0] Phase;
  logic       Busy;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    string      name;
    int         mask;
    logic [5:0] out;
    logic [5:0] lvl;
    logic [2:0] ph;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  noise_envelope #(.PRESCALE(PRESCALE)) dut (
    .CLK(CLK), .RST(RST), .Sample(Sample), .KeyOn(KeyOn), .KeyOff(KeyOff),
    .AttackRate(AttackRate), .DecayRate(DecayRate), .SustainLvl(SustainLvl),
    .ReleaseRate(ReleaseRate), .Output(Output), .Level(Level), .Phase(Phase),
    .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Edge counter: after rising edge n, cyc == n.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic push(input exp_t e);
    int i;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > e.cyc) i--;
    sb.insert(i, e);
  endtask

  task automatic exp_state(input int c, input string nm, input int l, input int p);
    exp_t e;
    e.cyc = c; e.name = nm; e.mask = M_ST; e.out = '0;
    e.lvl = 6'(l); e.ph = 3'(p); e.busy = (p != 0);
    push(e);
  endtask

  task automatic exp_out(input int c, input string nm, input int o);
    exp_t e;
    e.cyc = c; e.name = nm; e.mask = M_OUT; e.out = 6'(o);
    e.lvl = '0; e.ph = '0; e.busy = 1'b0;
    push(e);
  endtask

  task automatic exp_all(input int c, input string nm, input int o, input int l, input int p);
    exp_t e;
    e.cyc = c; e.name = nm; e.mask = M_OUT | M_ST; e.out = 6'(o);
    e.lvl = 6'(l); e.ph = 3'(p); e.busy = (p != 0);
    push(e);
  endtask

  // Advance to the falling edge following rising edge n.
  task automatic go(input int n);
    if (cyc > n) begin
      n_tests++;
      n_fail++;
      $display("FAIL schedule: at cyc %0d, wanted cyc %0d", cyc, n);
    end
    while (cyc < n) @(negedge CLK);
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge CLK) begin : mon
    exp_t e;
    logic bad;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      bad = 1'b0;
      if (e.cyc < cyc) bad = 1'b1;
      if ((e.mask & M_OUT) != 0 && Output !== e.out) bad = 1'b1;
      if ((e.mask & 2) != 0 && Level !== e.lvl) bad = 1'b1;
      if ((e.mask & 4) != 0 && Phase !== e.ph) bad = 1'b1;
      if ((e.mask & 8) != 0 && Busy !== e.busy) bad = 1'b1;
      if (bad) begin
        n_fail++;
        $display("FAIL %s @cyc %0d (checked %0d): got Output=%0d Level=%0d Phase=%0d Busy=%0d, want Output=%0d Level=%0d Phase=%0d Busy=%0d mask=%0d",
                 e.name, e.cyc, cyc, Output, Level, Phase, Busy, e.out, e.lvl, e.ph, e.busy, e.mask);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held three edges with KeyOn and full Sample active.
    for (int c = 1; c <= 3; c++) exp_all(c, "reset_hold", 0, 0, 0);
    // Full ADSR cycle, all rates 0, SustainLvl 8.
    exp_state(4,   "keyon_attack",     0,  1);
    exp_state(6,   "pre_first_tick",   0,  1);
    exp_state(7,   "first_tick",       1,  1);
    exp_state(254, "attack_62",        62, 1);
    exp_state(255, "attack_top_decay", 63, 2);
    exp_out(255,   "out_lvl62",        61);
    exp_out(256,   "out_lvl63",        63);
    exp_state(379, "decay_32",         32, 2);
    exp_state(380, "sustain_32",       32, 3);
    exp_out(380,   "out_lvl32",        31);
    exp_state(400, "sustain_hold",     32, 3);

    go(3);
    RST = 1'b0;
    go(4);
    KeyOn = 1'b0;

    go(400);
    KeyOff = 1'b1;
    exp_state(401, "keyoff_release", 32, 4);
    exp_state(403, "release_step",   31, 4);
    exp_state(527, "release_zero",   0,  4);
    exp_state(528, "release_idle",   0,  0);
    exp_out(528,   "out_lvl0",       0);
    go(401);
    KeyOff = 1'b0;

    // Rate timing: AttackRate 3 steps every 16 clocks, then rate 0 every 4.
    go(530);
    AttackRate = 4'd3;
    KeyOn = 1'b1;
    exp_state(531, "rate_keyon",   0, 1);
    exp_state(546, "rate3_wait1",  0, 1);
    exp_state(547, "rate3_step1",  1, 1);
    exp_state(562, "rate3_wait2",  1, 1);
    exp_state(563, "rate3_step2",  2, 1);
    go(531);
    KeyOn = 1'b0;
    go(565);
    AttackRate = 4'd0;
    SustainLvl = 4'd10;
    exp_state(566, "rate0_wait",   2,  1);
    exp_state(567, "rate0_step",   3,  1);
    exp_state(571, "rate0_step2",  4,  1);
    exp_state(807, "attack_top2",  63, 2);
    exp_state(899, "decay_40",     40, 2);
    exp_state(900, "sustain_40",   40, 3);

    // Retrigger from RELEASE continues from the current level.
    go(902);
    KeyOff = 1'b1;
    exp_state(903, "release_40", 40, 4);
    exp_state(983, "release_20", 20, 4);
    go(903);
    KeyOff = 1'b0;
    go(984);
    KeyOn = 1'b1;
    exp_state(985, "retrig_attack", 20, 1);
    exp_state(987, "retrig_21",     21, 1);
    exp_state(991, "retrig_22",     22, 1);
    exp_state(1248, "sustain_40b",  40, 3);
    go(985);
    KeyOn = 1'b0;

    // KeyOn and KeyOff together in SUSTAIN: KeyOn wins.
    go(1250);
    KeyOn = 1'b1;
    KeyOff = 1'b1;
    exp_state(1251, "on_off_same",  40, 1);
    exp_state(1343, "decay_again",  63, 2);
    go(1251);
    KeyOn = 1'b0;
    KeyOff = 1'b0;

    // Reset in DECAY with KeyOn and KeyOff high aborts everything.
    go(1348);
    RST = 1'b1;
    KeyOn = 1'b1;
    KeyOff = 1'b1;
    exp_all(1349, "rst_in_decay", 0, 0, 0);
    go(1349);
    RST = 1'b0;
    KeyOn = 1'b0;
    KeyOff = 1'b0;

    // KeyOff in IDLE is ignored.
    go(1351);
    KeyOff = 1'b1;
    exp_state(1352, "keyoff_idle", 0, 0);
    go(1352);
    KeyOff = 1'b0;

    // Attack to 63, decay to sustain at 16, with Sample=0 checks near the top.
    go(1353);
    KeyOn = 1'b1;
    SustainLvl = 4'd4;
    exp_state(1354, "attack3", 0, 1);
    go(1354);
    KeyOn = 1'b0;
    go(1603);
    Sample = 6'd0;
    exp_out(1604, "zero_lvl62", 0);
    exp_state(1605, "attack_top3", 63, 2);
    exp_out(1606, "zero_lvl63", 0);
    go(1606);
    Sample = 6'd63;
    exp_out(1607, "full_lvl63", 63);
    exp_state(1794, "sustain_16", 16, 3);

    // Scaling at Level 16: alternating 0/63 samples give 0/15, one cycle late.
    go(1800);
    for (int i = 0; i < 8; i++) begin
      Sample = (i % 2 != 0) ? 6'd63 : 6'd0;
      exp_out(cyc + 1, "scale16", (i % 2 != 0) ? 15 : 0);
      @(negedge CLK);
    end
    Sample = 6'd63;

    go(1815);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation for cyc %0d never checked", e.name, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
